// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// error codes and small decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ERR    = 2'd2
   } lsu_state_e;

   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   // Unsigned widths exist only for loads.
   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      logic ok;
      ok = 1'b0;
      if (f3 == F3_B || f3 == F3_H || f3 == F3_W) ok = 1'b1;
      else if ((f3 == F3_BU || f3 == F3_HU) && !we) ok = 1'b1;
      return ok;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      if ((f3 == F3_H || f3 == F3_HU) && a[0]) bad = 1'b1;
      else if (f3 == F3_W && a != 2'b00) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_addr_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and a latch is never inferred.
   always_comb begin
      wstrb_o = 4'b1111;
      wdata_o = wdata_i;
      unique case (st_funct3_i)
         F3_B: begin
            wstrb_o = 4'b0001 << st_addr_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         F3_H: begin
            wstrb_o = st_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = rdata_i[7:0];
      case (ld_addr_i)
         2'd1:    ld_byte = rdata_i[15:8];
         2'd2:    ld_byte = rdata_i[23:16];
         2'd3:    ld_byte = rdata_i[31:24];
         default: ld_byte = rdata_i[7:0];
      endcase
      ld_half = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      rdata_o = rdata_i;
      unique case (ld_funct3_i)
         F3_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   rdata_o = {24'h0, ld_byte};
         F3_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   rdata_o = {16'h0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request latch, IDLE/ACCESS/ERR FSM, timeout counter
// and registered memory/writeback/error outputs. Optional macro: MISALIGN_CHECK_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        stall,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] err_addr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

   lsu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       funct3_q;
   logic [31:0]      addr_q;
   logic [4:0]       rd_q;

   logic        mem_valid_q, mem_we_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_wstrb_q;
   logic        wb_valid_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;
   logic        err_q;
   logic [1:0]  err_code_q;
   logic [31:0] err_addr_q;

   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [31:0] ld_data;
   logic        bad_align;

   lsu_align u_align (
      .st_funct3_i (req_funct3),
      .st_addr_i   (req_addr[1:0]),
      .wdata_i     (req_wdata),
      .ld_funct3_i (funct3_q),
      .ld_addr_i   (addr_q[1:0]),
      .rdata_i     (mem_rdata),
      .wstrb_o     (st_strb),
      .wdata_o     (st_data),
      .rdata_o     (ld_data)
   );

`ifdef MISALIGN_CHECK_EN
   assign bad_align = f3_misaligned(req_funct3, req_addr[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   assign cnt_d = cnt_q + CNT_W'(1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= '0;
         mem_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         err_addr_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         err_q      <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (!f3_legal(req_funct3, req_we)) begin
                     state_q    <= ERR;
                     err_q      <= 1'b1;
                     err_code_q <= ERR_ILLEGAL;
                     err_addr_q <= req_addr;
                  end else if (bad_align) begin
                     state_q    <= ERR;
                     err_q      <= 1'b1;
                     err_code_q <= ERR_MISALIGN;
                     err_addr_q <= req_addr;
                  end else begin
                     state_q     <= ACCESS;
                     cnt_q       <= '0;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= {req_addr[31:2], 2'b00};
                     mem_we_q    <= req_we;
                     mem_wstrb_q <= req_we ? st_strb : 4'b0000;
                     mem_wdata_q <= req_we ? st_data : 32'h0;
                  end
               end
            end
            ACCESS: begin
               // mem_ready is checked first so it wins over a same-cycle timeout.
               if (mem_ready) begin
                  state_q     <= IDLE;
                  mem_valid_q <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= '0;
                  if (!mem_we_q) begin
                     wb_valid_q <= (rd_q != 5'd0);
                     wb_rd_q    <= rd_q;
                     wb_data_q  <= ld_data;
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_d == TMO)) begin
                  state_q     <= ERR;
                  cnt_q       <= cnt_d;
                  mem_valid_q <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= '0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_TIMEOUT;
                  err_addr_q  <= addr_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: the latched request fields carry no reset; they are only consumed
   // in ACCESS/ERR, which can only be reached after a fresh latch in IDLE.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_valid) begin
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         rd_q     <= req_rd;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign stall     = (state_q != IDLE) || (req_valid && !req_ready);

   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4); expectations follow
// MISALIGN_CHECK_EN when the build defines it.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall, err;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   int n_vec  = 0;
   int n_miss = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .stall      (stall),
      .err        (err),
      .err_code   (err_code),
      .err_addr   (err_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_rd     = rd;
      check("req_ready_at_issue", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   // Simple load with immediate mem_ready; checks writeback next cycle.
   task automatic load_now(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic exp_wb, input logic [31:0] exp_data);
      issue(1'b0, f3, addr, 32'h0, rd);
      check({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
      check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      mem_ready = 1'b1;
      mem_rdata = rdata;
      step();
      mem_ready = 1'b0;
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'(exp_wb));
      if (exp_wb) begin
         check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
         check({tag, "_wb_data"}, wb_data, exp_data);
      end
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0; req_rd = '0; mem_ready = 1'b0; mem_rdata = '0;
      step(); step();

      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      reset_n = 1'b1;
      step();

      // LB lane 3, sign-extended; wb_valid exactly two cycles after accept.
      issue(1'b0, F3_B, 32'h0000_1003, 32'h0, 5'd7);
      check("lb_mem_valid", 32'(mem_valid), 32'd1);
      check("lb_mem_addr", mem_addr, 32'h0000_1000);
      check("lb_mem_we", 32'(mem_we), 32'd0);
      check("lb_stall", 32'(stall), 32'd1);
      check("lb_req_ready_busy", 32'(req_ready), 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h80AA_BBCC;
      step();
      mem_ready = 1'b0;
      check("lb_wb_valid", 32'(wb_valid), 32'd1);
      check("lb_wb_rd", 32'(wb_rd), 32'd7);
      check("lb_wb_data", wb_data, 32'hFFFF_FF80);
      check("lb_mem_valid_drop", 32'(mem_valid), 32'd0);
      step();
      check("lb_wb_pulse_end", 32'(wb_valid), 32'd0);

      // LHU upper half with three wait cycles; ready arrives with cnt at 3.
      issue(1'b0, F3_HU, 32'h0000_2002, 32'h0, 5'd9);
      mem_rdata = 32'h8001_1234;
      for (int i = 0; i < 3; i++) begin
         check("lhu_wait_mem_valid", 32'(mem_valid), 32'd1);
         check("lhu_wait_wb", 32'(wb_valid), 32'd0);
         step();
      end
      check("lhu_mem_valid_4th", 32'(mem_valid), 32'd1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("lhu_wb_valid", 32'(wb_valid), 32'd1);
      check("lhu_wb_data", wb_data, 32'h0000_8001);
      check("lhu_err", 32'(err), 32'd0);

      // SB lane 1: strobe and replicated data, no writeback.
      issue(1'b1, F3_B, 32'h0000_0001, 32'h0000_00A5, 5'd3);
      check("sb_mem_we", 32'(mem_we), 32'd1);
      check("sb_wstrb", 32'(mem_wstrb), 32'h2);
      check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb_mem_addr", mem_addr, 32'h0000_0000);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("sb_no_wb", 32'(wb_valid), 32'd0);
      check("sb_req_ready", 32'(req_ready), 32'd1);

      // SH upper lane.
      issue(1'b1, F3_H, 32'h0000_0012, 32'h1234_BEEF, 5'd0);
      check("sh_wstrb", 32'(mem_wstrb), 32'hC);
      check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      check("sh_mem_addr", mem_addr, 32'h0000_0010);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;

      // SW and load-extension variants.
      issue(1'b1, F3_W, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0);
      check("sw_wstrb", 32'(mem_wstrb), 32'hF);
      check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      load_now("lh_low", F3_H, 32'h0000_0100, 32'h1234_F00D, 5'd10, 1'b1, 32'hFFFF_F00D);
      load_now("lh_high", F3_H, 32'h0000_0102, 32'h7ABC_8000, 5'd11, 1'b1, 32'h0000_7ABC);
      load_now("lbu_lane1", F3_BU, 32'h0000_0101, 32'h0000_8000, 5'd12, 1'b1, 32'h0000_0080);
      load_now("lb_pos", F3_B, 32'h0000_0102, 32'h0055_0000, 5'd13, 1'b1, 32'h0000_0055);
      load_now("lw_rd0", F3_W, 32'h0000_0104, 32'h1111_2222, 5'd0, 1'b0, 32'h0);

      // Illegal funct3: store-unsigned and reserved code.
      issue(1'b1, F3_BU, 32'h0000_0300, 32'h0, 5'd1);
      check("ill_st_err", 32'(err), 32'd1);
      check("ill_st_code", 32'(err_code), 32'(ERR_ILLEGAL));
      check("ill_st_addr", err_addr, 32'h0000_0300);
      check("ill_st_mem_valid", 32'(mem_valid), 32'd0);
      check("ill_st_req_ready", 32'(req_ready), 32'd0);
      step();
      check("ill_st_err_end", 32'(err), 32'd0);
      check("ill_st_ready_back", 32'(req_ready), 32'd1);
      issue(1'b0, 3'b011, 32'h0000_0304, 32'h0, 5'd1);
      check("ill_ld_code", 32'(err_code), 32'(ERR_ILLEGAL));
      check("ill_ld_err", 32'(err), 32'd1);
      step();

      // LW at address 6: misaligned error with the macro, word at 4 without it.
`ifdef MISALIGN_CHECK_EN
      issue(1'b0, F3_W, 32'h0000_0006, 32'h0, 5'd4);
      check("mis_err", 32'(err), 32'd1);
      check("mis_code", 32'(err_code), 32'(ERR_MISALIGN));
      check("mis_addr", err_addr, 32'h0000_0006);
      check("mis_mem_valid", 32'(mem_valid), 32'd0);
      step();
      check("mis_mem_valid2", 32'(mem_valid), 32'd0);
      check("mis_ready_back", 32'(req_ready), 32'd1);
`else
      load_now("lw_unaligned", F3_W, 32'h0000_0006, 32'hCAFE_F00D, 5'd4, 1'b1, 32'hCAFE_F00D);
      check("lw_unaligned_err", 32'(err), 32'd0);
      load_now("lh_odd", F3_H, 32'h0000_0003, 32'h9876_0000, 5'd6, 1'b1, 32'hFFFF_9876);
`endif

      // Timeout: four mem_valid cycles, then err code 10, then req_ready.
      issue(1'b0, F3_W, 32'h0000_0400, 32'h0, 5'd8);
      for (int i = 0; i < 4; i++) begin
         check("tmo_mem_valid", 32'(mem_valid), 32'd1);
         check("tmo_no_err", 32'(err), 32'd0);
         step();
      end
      check("tmo_mem_valid_drop", 32'(mem_valid), 32'd0);
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_code", 32'(err_code), 32'(ERR_TIMEOUT));
      check("tmo_addr", err_addr, 32'h0000_0400);
      check("tmo_req_ready_err", 32'(req_ready), 32'd0);
      check("tmo_no_wb", 32'(wb_valid), 32'd0);
      step();
      check("tmo_req_ready", 32'(req_ready), 32'd1);
      check("tmo_err_end", 32'(err), 32'd0);

      // Back-to-back LW then SW accepted during the writeback; reset aborts SW.
      issue(1'b0, F3_W, 32'h0000_0040, 32'h0, 5'd5);
      mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
      step();
      mem_ready = 1'b0;
      check("b2b_wb_valid", 32'(wb_valid), 32'd1);
      check("b2b_wb_rd", 32'(wb_rd), 32'd5);
      check("b2b_wb_data", wb_data, 32'h1122_3344);
      issue(1'b1, F3_W, 32'h0000_0044, 32'h5566_7788, 5'd0);
      check("b2b_sw_mem_valid", 32'(mem_valid), 32'd1);
      check("b2b_sw_wstrb", 32'(mem_wstrb), 32'hF);
      check("b2b_sw_wb_end", 32'(wb_valid), 32'd0);
      reset_n = 1'b0;
      step();
      check("abort_mem_valid", 32'(mem_valid), 32'd0);
      check("abort_mem_we", 32'(mem_we), 32'd0);
      check("abort_wstrb", 32'(mem_wstrb), 32'd0);
      check("abort_mem_wdata", mem_wdata, 32'h0);
      check("abort_wb_valid", 32'(wb_valid), 32'd0);
      check("abort_wb_data", wb_data, 32'h0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_stall", 32'(stall), 32'd0);
      reset_n = 1'b1;
      step();
      check("post_abort_mem_valid", 32'(mem_valid), 32'd0);
      check("post_abort_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
